// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   pc_src_e      : pc_source encodings (PC+4, branch, jump, hold)
//   fetch_state_e : fetch FSM state encoding
//   OPCODE_MSB/LSB: opcode field position inside the instruction word
//   RESET_PC      : PC value after reset
//   branch_offset : sign-extended, word-scaled branch displacement
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_HOLD   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } fetch_state_e;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next_calc.sv
// pc_next_calc: combinational next-PC selection.
//   pc           : current (word-aligned) PC
//   pc_source    : 00 PC+4, 01 branch, 10 jump, 11 hold
//   branch_taken : branch condition from the datapath
//   imm_field    : instr[25:0] (jump index; [15:0] is the branch immediate)
//   pc_plus4     : pc + 4, wrapping modulo 2^32
//   pc_next      : PC to load when pc_write is asserted
module pc_next_calc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_source,
    input  logic        branch_taken,
    input  logic [25:0] imm_field,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc_plus4 + branch_offset(imm_field[15:0]);
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign jump_tgt   = {pc_plus4[31:28], imm_field, 2'b00};

    always_comb begin
        pc_next = pc;
        case (pc_src_e'(pc_source))
            PC_SRC_PLUS4:  pc_next = pc_plus4;
            PC_SRC_BRANCH: pc_next = branch_taken ? branch_tgt : pc_plus4;
            PC_SRC_JUMP:   pc_next = jump_tgt;
            PC_SRC_HOLD:   pc_next = pc;
            default:       pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, instruction register and memory-fetch FSM.
//   clk, rst                 : clock, async active-high reset
//   fetch_start              : request a fetch at the current pc (IDLE only)
//   pc_write, pc_source,
//   branch_taken             : PC update strobe and selection
//   mem_req/mem_addr/
//   mem_rdata/mem_ack        : instruction-memory handshake
//   instr, opcode            : instruction register and its opcode field
//   pc, pc_plus4, instr_valid: program counter, pc+4, instr matches pc
// Optional: define FETCH_PERF_CNT_EN to add saturating fetch_count and
// stall_count outputs.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [1:0]  pc_source,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    fetch_state_e state, state_nx;
    logic [31:2]  pc_q;        // low bits are structurally zero
    logic [31:0]  pc_next;
    logic [31:0]  fetch_addr;  // address of the outstanding fetch
    logic         stale;       // pc moved while the fetch was in flight
    logic         busy;
    logic         start_take;
    logic         ack_take;

    assign pc     = {pc_q, 2'b00};
    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

    pc_next_calc u_pc_next (
        .pc           (pc),
        .pc_source    (pc_source),
        .branch_taken (branch_taken),
        .imm_field    (instr[25:0]),
        .pc_plus4     (pc_plus4),
        .pc_next      (pc_next)
    );

    assign busy       = (state == ST_REQ) || (state == ST_WAIT);
    assign start_take = (state == ST_IDLE) && fetch_start;
    assign ack_take   = busy && mem_ack;

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state)
            ST_IDLE: if (fetch_start) state_nx = ST_REQ;
            ST_REQ, ST_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = fetch_addr;
                state_nx = mem_ack ? ST_DONE : ST_WAIT;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC[31:2];
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_addr  <= '0;
            stale       <= 1'b0;
        end else begin
            state <= state_nx;
            if (pc_write)
                pc_q <= pc_next[31:2];
            if (ack_take)
                instr <= mem_rdata;
            // A same-cycle pc_write is applied before the fetch is issued.
            if (start_take)
                fetch_addr <= pc_write ? pc_next : pc;
            if (state == ST_DONE)
                instr_valid <= !(stale || pc_write);
            else if (pc_write || fetch_start)
                instr_valid <= 1'b0;
            if (start_take)
                stale <= 1'b0;
            else if (pc_write && (state != ST_IDLE))
                stale <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (ack_take && (fetch_count != 16'hFFFF))
                fetch_count <= fetch_count + 16'd1;
            if ((state == ST_WAIT) && !mem_ack && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a transaction-level model is compared
// against the DUT every falling edge, plus literal expectations per scenario.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_write = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic        branch_taken = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_start  (fetch_start),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_addr, m_npc;
    bit          m_valid, m_pending, m_first, m_done, m_stale;
    bit          o_pend, o_done, o_idle;
    int          m_fcnt, m_scnt;

    function automatic logic [31:0] next_pc(input logic [1:0] s, input logic [31:0] p,
                                            input logic [31:0] ir, input logic bt);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        int                 off;
        p4  = p + 32'd4;
        imm = ir[15:0];
        off = int'(imm) * 4;
        case (s)
            2'd0:    return p4;
            2'd1:    return bt ? p4 + 32'(off) : p4;
            2'd2:    return (p4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            default: return p;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_instr = 0; m_addr = 0; m_valid = 0; m_pending = 0;
            m_first = 0; m_done = 0; m_stale = 0; m_fcnt = 0; m_scnt = 0;
        end else begin
            o_pend = m_pending;
            o_done = m_done;
            o_idle = !m_pending && !m_done;
            m_npc  = next_pc(pc_source, m_pc, m_instr, branch_taken);
            if (o_done)                      m_valid = !(m_stale || pc_write);
            else if (pc_write || fetch_start) m_valid = 0;
            m_done = 0;
            if (o_pend && mem_ack) begin
                m_instr = mem_rdata; m_pending = 0; m_done = 1;
                if (m_fcnt < 65535) m_fcnt++;
            end else if (o_pend && !m_first) begin
                if (m_scnt < 65535) m_scnt++;
            end
            m_first = 0;
            if (o_idle && fetch_start) begin
                m_pending = 1; m_first = 1; m_stale = 0;
                m_addr = pc_write ? m_npc : m_pc;
            end else if (pc_write && !o_idle) begin
                m_stale = 1;
            end
            if (pc_write) m_pc = m_npc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("opcode", {26'd0, opcode}, m_instr >> 26);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_pending});
            chk("mem_addr", mem_addr, m_pending ? m_addr : 32'd0);
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", {16'd0, fetch_count}, 32'(m_fcnt));
            chk("stall_count", {16'd0, stall_count}, 32'(m_scnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pcw(input logic [1:0] src, input logic bt);
        pc_write = 1'b1; pc_source = src; branch_taken = bt;
        tick();
        pc_write = 1'b0; branch_taken = 1'b0;
    endtask

    // noack = cycles the request stays unacknowledged (REQ cycle included)
    task automatic fetch(input logic [31:0] data, input int noack, input logic [31:0] addr);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < noack; i++) begin
            @(negedge clk);
            chk("lit_mem_req", {31'd0, mem_req}, 32'd1);
            chk("lit_mem_addr", mem_addr, addr);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = data;
        @(negedge clk);
        chk("lit_mem_addr_ack", mem_addr, addr);
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);

        // Zero-wait fetch: valid three cycles after fetch_start
        fetch(32'h4822_0005, 0, 32'h0);
        @(negedge clk);
        chk("f0_instr", instr, 32'h4822_0005);
        chk("f0_opcode", {26'd0, opcode}, 32'h12);
        chk("f0_valid", {31'd0, instr_valid}, 32'd1);

        // Backward branch from 0 wraps, then PC+4 wraps back to 0
        fetch(32'h1000_FFFE, 0, 32'h0);
        pcw(2'b01, 1'b1);
        @(negedge clk); chk("br_wrap", pc, 32'hFFFF_FFFC);
        pcw(2'b00, 1'b0);
        @(negedge clk); chk("plus4_wrap", pc, 32'h0);

        // Jump to 0x100, then branch taken/not taken from 0x100
        fetch(32'h0800_0040, 0, 32'h0);
        pcw(2'b10, 1'b0);
        @(negedge clk); chk("jmp_100", pc, 32'h100);
        fetch(32'h1000_FFFE, 0, 32'h100);
        pcw(2'b01, 1'b1);
        @(negedge clk); chk("br_taken", pc, 32'h0FC);
        pcw(2'b00, 1'b0);
        pcw(2'b01, 1'b0);
        @(negedge clk); chk("br_not_taken", pc, 32'h104);
        pcw(2'b11, 1'b1);
        @(negedge clk); chk("hold", pc, 32'h104);

        // Fresh reset; slow memory at 0x10 (5 stall cycles in WAIT)
        do_reset();
        repeat (4) pcw(2'b00, 1'b0);
        fetch(32'h0C00_7FFF, 6, 32'h10);
`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        chk("lit_stall_count", {16'd0, stall_count}, 32'd5);
        chk("lit_fetch_count", {16'd0, fetch_count}, 32'd1);
`endif
        // Each taken branch with imm 0x7FFF advances pc by 0x20000
        repeat (6144) pcw(2'b01, 1'b1);
        @(negedge clk); chk("br_climb", pc, 32'h3000_0010);
        fetch(32'h0800_0040, 0, 32'h3000_0010);
        pcw(2'b10, 1'b0);
        @(negedge clk); chk("jmp_region", pc, 32'h3000_0100);

        // pc_write and a stray fetch_start while waiting on memory
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        tick();
        pc_write = 1'b1; pc_source = 2'b00; tick(); pc_write = 1'b0;
        @(negedge clk);
        chk("wait_addr_kept", mem_addr, 32'h3000_0100);
        chk("wait_pc_moved", pc, 32'h3000_0104);
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h2108_FFFF; tick(); mem_ack = 1'b0;
        tick();
        @(negedge clk);
        chk("stale_instr", instr, 32'h2108_FFFF);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("no_queued_fetch", {31'd0, mem_req}, 32'd0);

        // fetch_start together with pc_write uses the updated pc
        fetch_start = 1'b1; pc_write = 1'b1; pc_source = 2'b00;
        tick();
        fetch_start = 1'b0; pc_write = 1'b0;
        @(negedge clk);
        chk("sim_addr", mem_addr, 32'h3000_0108);
        mem_ack = 1'b1; mem_rdata = 32'h8C01_0004; tick(); mem_ack = 1'b0;
        tick();
        @(negedge clk);
        chk("sim_valid", {31'd0, instr_valid}, 32'd1);

        // Reset mid-WAIT takes effect without a clock; late ack is ignored
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        mem_ack = 1'b0;
        tick();
        @(negedge clk);
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_idle", {31'd0, mem_req}, 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port fetch_start, input, 1 bit: a one-cycle pulse from the control FSM in its IF state that requests a fetch at the current PC.
REQ-004 SHALL have port pc_write, input, 1 bit: a one-cycle pulse that commits a PC update selected by pc_source.
REQ-005 SHALL have port pc_source, input, 2 bits: 00 = PC+4, 01 = branch, 10 = jump, 11 = hold.
REQ-006 SHALL have port branch_taken, input, 1 bit: the datapath's branch-condition result.
REQ-007 SHALL have ports mem_req (output, 1), mem_addr (output, 32), mem_rdata (input, 32) and mem_ack (input, 1): the instruction-memory handshake.
REQ-008 SHALL have ports instr (output, 32, the instruction register) and opcode (output, 6, equal to instr[31:26], feeding the control FSM).
REQ-009 SHALL have ports pc (output, 32), pc_plus4 (output, 32) and instr_valid (output, 1, high while instr holds the word fetched from the current pc).

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
- IDLE goes to REQ on fetch_start.
- REQ drives mem_req=1 and mem_addr=pc, then goes to WAIT.
- WAIT holds mem_req=1 with a stable mem_addr until mem_ack.
- On mem_ack, the FSM latches mem_rdata into instr and goes to DONE.
- DONE sets instr_valid=1 and returns to IDLE on the next cycle.
REQ-011 SHALL accept an ack in the same cycle as the request, so REQ to DONE takes 1 cycle and minimum fetch latency is fetch_start to instr_valid in 3 cycles.
REQ-012 SHALL ignore fetch_start while not in IDLE, with no queuing.
REQ-013 SHALL ignore mem_ack outside REQ/WAIT.
REQ-014 SHALL keep instr_valid high from DONE until the next fetch_start or pc_write, then clear it.
REQ-015 SHALL, on pc_write in any state, update pc by pc_source as follows:
- 00: pc = pc_plus4.
- 01: pc = pc_plus4 + (sign-extended instr[15:0] << 2) if branch_taken, else pc_plus4.
- 10: pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
- 11: pc unchanged.
REQ-016 SHALL compute pc_plus4 combinationally from pc, with 32-bit arithmetic wrapping modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-017 SHALL, on pc_write during REQ/WAIT, finish the outstanding fetch at the old address, latch instr, and still clear instr_valid.
REQ-018 SHALL force pc[1:0] to 00 at all times.
REQ-019 SHALL, on simultaneous fetch_start and pc_write in IDLE, apply the PC update first, so the fetch uses the new PC on the following cycle.

Reset
REQ-020 SHALL, while rst=1, immediately force the following regardless of the clock:
- state = IDLE;
- pc = 0x00000000, instr = 0x00000000;
- instr_valid = 0, mem_req = 0, mem_addr = 0.
REQ-021 SHALL abandon any in-flight fetch when rst asserts mid-fetch, and SHALL ignore a later mem_ack from that fetch.

Configuration
REQ-022 SHALL, when FETCH_PERF_CNT_EN is defined, add outputs fetch_count (16 bits, incremented on each DONE entry) and stall_count (16 bits, incremented each cycle in WAIT without mem_ack). Both SHALL saturate at 0xFFFF and reset to 0.
REQ-023 SHALL, when FETCH_PERF_CNT_EN is undefined, omit both counter ports and all counter logic.

Structure
REQ-024 SHALL take the pc_source encodings, the FSM state encoding, the opcode field position [31:26] and the reset PC constant from a shared package.
REQ-025 SHALL use one sub-module, pc_next_calc: combinational next-PC selection plus branch/jump target arithmetic; the FSM and registers stay in instr_fetch.

Verification
REQ-026 SHALL cover: reset, then fetch_start with mem_ack given in the REQ cycle and mem_rdata=0x48220005 -> instr=0x48220005, opcode=6'b010010, instr_valid=1 three cycles after fetch_start.
REQ-027 SHALL cover: pc=0x100, pc_write with pc_source=01, branch_taken=1, instr[15:0]=0xFFFE -> pc=0x0FC; the same with branch_taken=0 -> pc=0x104.
REQ-028 SHALL cover: pc=0x30000010, pc_write with pc_source=10, instr[25:0]=0x0000040 -> pc=0x30000100.
REQ-029 SHALL cover: mem_ack delayed 5 cycles -> mem_req high and mem_addr stable throughout; with FETCH_PERF_CNT_EN defined, stall_count=5 and fetch_count=1.
REQ-030 SHALL cover: rst asserted during WAIT, then a stale mem_ack -> instr stays 0, instr_valid=0, state IDLE.
REQ-031 SHALL cover: pc=0xFFFFFFFC, pc_write with pc_source=00 -> pc=0x00000000.
